// File: rtl/afifo_write_arbiter_pkg.sv
// Shared definitions for the AFIFOChain write-port arbiter: FSM state encoding
// and the default chunk length derived from the chain geometry.
package afifo_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_XFER       = 2'd2,
    ST_RELEASE    = 2'd3
  } state_t;

  // Chain geometry: N_FIFO primitives of FIFO_BITS each, one chunk is half of it.
  localparam int N_FIFO    = 8;
  localparam int FIFO_BITS = 4096;
  localparam int DEFAULT_W = 8;

  function automatic int chunk_len_for(input int n_fifo, input int w);
    return (n_fifo / 2) * FIFO_BITS / w;
  endfunction

  localparam int DEFAULT_CHUNK_LEN = chunk_len_for(N_FIFO, DEFAULT_W);

endpackage

// File: rtl/afifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester found when
// searching upward from pointer+1 (mod N), as one-hot and as an index.
module afifo_write_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(pointer) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        pick_idx  = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_write_arbiter.sv
// Shares one AFIFOChain write port between N requesters in whole CHUNK_LEN chunks.
// Optional macro AFIFO_WRITE_ARB_PAD_EN: a requester dropping req mid-chunk is padded out with PAD_WORD.
module afifo_write_arbiter
  import afifo_write_arbiter_pkg::*;
#(
  parameter int           W         = 8,
  parameter int           N         = 2,
  parameter int           CHUNK_LEN = DEFAULT_CHUNK_LEN,
  parameter logic [W-1:0] PAD_WORD  = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   grant,
  output logic           chunk_done,
  input  logic           fifo_prop_w_ready,
  output logic           fifo_w_trigger,
  output logic [W-1:0]   fifo_w_data,
  input  logic           fifo_w_ready,
  output logic           overflow,
  output logic           busy
);

  localparam int CW = $clog2(CHUNK_LEN + 1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t        state_reg, state_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [PW-1:0] gidx_reg, gidx_next;
  logic [PW-1:0] pointer_reg, pointer_next;
  logic [CW-1:0] count_reg, count_next;
  logic          trigger_reg, trigger_next;
  logic [W-1:0]  data_reg, data_next;
  logic          chunk_done_reg, chunk_done_next;
  logic          overflow_reg, overflow_next;
`ifdef AFIFO_WRITE_ARB_PAD_EN
  logic          pad_reg, pad_next;
`endif

  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic [W-1:0]  lane [N];
  logic          take;
  logic [W-1:0]  word;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*W +: W];
  end

  afifo_write_arbiter_rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req      (req),
    .pointer  (pointer_reg),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      gidx_reg       <= '0;
      pointer_reg    <= '0;
      count_reg      <= '0;
      trigger_reg    <= 1'b0;
      data_reg       <= '0;
      chunk_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
`ifdef AFIFO_WRITE_ARB_PAD_EN
      pad_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      gidx_reg       <= gidx_next;
      pointer_reg    <= pointer_next;
      count_reg      <= count_next;
      trigger_reg    <= trigger_next;
      data_reg       <= data_next;
      chunk_done_reg <= chunk_done_next;
      overflow_reg   <= overflow_next;
`ifdef AFIFO_WRITE_ARB_PAD_EN
      pad_reg        <= pad_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    gidx_next       = gidx_reg;
    pointer_next    = pointer_reg;
    count_next      = count_reg;
    trigger_next    = 1'b0;
    data_next       = data_reg;
    chunk_done_next = 1'b0;
    // A write strobe the FIFO could not accept is latched permanently.
    overflow_next   = overflow_reg | (trigger_reg & ~fifo_w_ready);
    take            = 1'b0;
    word            = lane[gidx_reg];
`ifdef AFIFO_WRITE_ARB_PAD_EN
    pad_next        = pad_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (|req) state_next = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (!(|req)) begin
          state_next = ST_IDLE;
        end else if (fifo_prop_w_ready) begin
          state_next = ST_XFER;
          grant_next = pick;
          gidx_next  = pick_idx;
          count_next = CW'(CHUNK_LEN);
        end
      end
      ST_XFER: begin
`ifdef AFIFO_WRITE_ARB_PAD_EN
        if (pad_reg) begin
          take = 1'b1;
          word = PAD_WORD;
        end else if (!req[gidx_reg]) begin
          pad_next   = 1'b1;
          grant_next = '0;
        end else begin
          take = in_valid[gidx_reg];
        end
`else
        take = in_valid[gidx_reg];
`endif
        if (take) begin
          trigger_next = 1'b1;
          data_next    = word;
          count_next   = count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            grant_next   = '0;
            pointer_next = gidx_reg;
            state_next   = ST_RELEASE;
`ifdef AFIFO_WRITE_ARB_PAD_EN
            pad_next     = 1'b0;
`endif
          end
        end
      end
      ST_RELEASE: begin
        // Dead cycle so prop_w_ready can fall before it is sampled again.
        chunk_done_next = 1'b1;
        state_next      = (|req) ? ST_WAIT_READY : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign grant          = grant_reg;
  assign chunk_done     = chunk_done_reg;
  assign fifo_w_trigger = trigger_reg;
  assign fifo_w_data    = data_reg;
  assign overflow       = overflow_reg;
  assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_afifo_write_arbiter.sv
// Self-checking bench for afifo_write_arbiter: directed scenarios plus a
// randomized run checked against a chunk-level round-robin model.
module tb_afifo_write_arbiter;

  localparam int           W   = 8;
  localparam int           N   = 2;
  localparam logic [W-1:0] PAD = 8'hA5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           prop = 1'b0;
  logic           w_ready = 1'b1;

  logic [N-1:0] g16, g4;
  logic         cd16, cd4, trig16, trig4, ovf16, ovf4, busy16, busy4;
  logic [W-1:0] data16, data4;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  afifo_write_arbiter #(.W(W), .N(N), .CHUNK_LEN(16), .PAD_WORD(PAD)) dut16 (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .grant(g16), .chunk_done(cd16), .fifo_prop_w_ready(prop),
    .fifo_w_trigger(trig16), .fifo_w_data(data16), .fifo_w_ready(w_ready),
    .overflow(ovf16), .busy(busy16)
  );

  afifo_write_arbiter #(.W(W), .N(N), .CHUNK_LEN(4), .PAD_WORD(PAD)) dut4 (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .grant(g4), .chunk_done(cd4), .fifo_prop_w_ready(prop),
    .fifo_w_trigger(trig4), .fifo_w_data(data4), .fifo_w_ready(w_ready),
    .overflow(ovf4), .busy(busy4)
  );

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1 << i);
  endfunction

  // Round-robin: first requester after the previous owner, wrapping around.
  function automatic int next_owner(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; in_valid = '0; in_data = '0; prop = 1'b0; w_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests++;
    if ({g16, cd16, trig16, ovf16, busy16, data16} !== '0) begin
      failed++; $display("FAIL reset16: outputs=%h expected 0", {g16, cd16, trig16, ovf16, busy16, data16});
    end
    tests++;
    if ({g4, cd4, trig4, ovf4, busy4, data4} !== '0) begin
      failed++; $display("FAIL reset4: outputs=%h expected 0", {g4, cd4, trig4, ovf4, busy4, data4});
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    pulse_reset();
    req = 2'b01; prop = 1'b1;
    step(); step();
    tests++;
    if (g16 !== 2'b01) begin failed++; $display("FAIL single_grant: grant=%b expected 01", g16); end
    for (int k = 0; k < 16; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(k)};
      step();
      tests++;
      if (trig16 !== 1'b1 || data16 !== 8'(k) || cd16 !== 1'b0) begin
        failed++; $display("FAIL single_word%0d: trig=%b data=%h done=%b expected 1 %h 0", k, trig16, data16, cd16, 8'(k));
      end
    end
    in_valid = '0; req = '0;
    step();
    tests++;
    if (cd16 !== 1'b1 || trig16 !== 1'b0 || g16 !== 2'b00) begin
      failed++; $display("FAIL single_done: done=%b trig=%b grant=%b expected 1 0 00", cd16, trig16, g16);
    end
    step();
    tests++;
    if (busy16 !== 1'b0 || cd16 !== 1'b0 || trig16 !== 1'b0) begin
      failed++; $display("FAIL single_idle: busy=%b done=%b trig=%b expected 0 0 0", busy16, cd16, trig16);
    end
    $display("[TB] single requester chunk checked");
  endtask

  task automatic test_contention();
    int owner, wcnt, chunks, cyc;
    logic exp_done;
    pulse_reset();
    req = 2'b11; prop = 1'b1;
    owner = next_owner(0, 2'b11);
    wcnt = 0; chunks = 0; cyc = 0; exp_done = 1'b0;
    while (chunks < 4 && cyc < 200) begin
      in_valid = 2'b11; in_data = {1'b1, 7'(cyc), 1'b0, 7'(cyc)};
      step();
      tests++;
      if (cd4 !== exp_done) begin failed++; $display("FAIL cont_done cyc%0d: done=%b expected %b", cyc, cd4, exp_done); end
      exp_done = 1'b0;
      tests++;
      if (busy4 !== 1'b1) begin failed++; $display("FAIL cont_busy cyc%0d: busy=%b expected 1", cyc, busy4); end
      if (g4 !== 2'b00) begin
        tests++;
        if (g4 !== onehot(owner)) begin failed++; $display("FAIL cont_grant cyc%0d: grant=%b expected %b", cyc, g4, onehot(owner)); end
      end
      if (trig4 === 1'b1) begin
        tests++;
        if (data4 !== {1'(owner), 7'(cyc)}) begin
          failed++; $display("FAIL cont_data cyc%0d: data=%h expected %h", cyc, data4, {1'(owner), 7'(cyc)});
        end
        wcnt++;
        if (wcnt == 4) begin
          $display("[TB] contention chunk %0d owner %0d", chunks, owner);
          wcnt = 0; chunks++; exp_done = 1'b1; owner = next_owner(owner, 2'b11);
        end
      end
      cyc++;
    end
    tests++;
    if (chunks != 4) begin failed++; $display("FAIL cont_timeout: chunks=%0d expected 4", chunks); end
    in_valid = '0;
    step();
    tests++;
    if (cd4 !== exp_done) begin failed++; $display("FAIL cont_last_done: done=%b expected %b", cd4, exp_done); end
  endtask

  task automatic test_backpressure();
    int bad;
    pulse_reset();
    req = 2'b01; prop = 1'b0; bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (g16 !== 2'b00 || trig16 !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin failed++; $display("FAIL bp_hold: %0d cycles with grant/trigger, expected 0", bad); end
    prop = 1'b1;
    step();
    tests++;
    if (g16 !== 2'b01) begin failed++; $display("FAIL bp_grant: grant=%b expected 01", g16); end
    $display("[TB] backpressure checked");
  endtask

  task automatic test_bubbles_overflow();
    int writes;
    logic ovf_exp, ovf_pend;
    pulse_reset();
    req = 2'b01; prop = 1'b1;
    step(); step();
    writes = 0; ovf_exp = 1'b0; ovf_pend = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c % 2 == 0) ? 2'b01 : 2'b00;
      in_data  = {8'h00, 8'(8'h40 + c)};
      step();
      if (ovf_pend) ovf_exp = 1'b1;
      ovf_pend = 1'b0; w_ready = 1'b1;
      tests++;
      if (trig16 !== (c % 2 == 0)) begin failed++; $display("FAIL bub_trig c%0d: trig=%b expected %b", c, trig16, (c % 2 == 0)); end
      if (trig16 === 1'b1) begin
        writes++;
        tests++;
        if (data16 !== 8'(8'h40 + c)) begin failed++; $display("FAIL bub_data c%0d: data=%h expected %h", c, data16, 8'(8'h40 + c)); end
        if (writes == 3) begin w_ready = 1'b0; ovf_pend = 1'b1; end
      end
      tests++;
      if (ovf16 !== ovf_exp) begin failed++; $display("FAIL bub_ovf c%0d: overflow=%b expected %b", c, ovf16, ovf_exp); end
    end
    tests++;
    if (writes != 4) begin failed++; $display("FAIL bub_count: writes=%0d expected 4", writes); end
    in_valid = '0;
    for (int c = 0; c < 3; c++) step();
    tests++;
    if (ovf16 !== 1'b1) begin failed++; $display("FAIL ovf_sticky: overflow=%b expected 1", ovf16); end
    rst = 1'b1; #1;
    tests++;
    if (ovf16 !== 1'b0) begin failed++; $display("FAIL ovf_clear: overflow=%b expected 0", ovf16); end
    rst = 1'b0;
    $display("[TB] bubbles and overflow checked, %0d writes", writes);
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req = 2'b01; prop = 1'b1;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(k)};
      step();
    end
    in_valid = '0;
    rst = 1'b1; #1;
    tests++;
    if (g16 !== 2'b00 || trig16 !== 1'b0 || busy16 !== 1'b0) begin
      failed++; $display("FAIL rmid_async: grant=%b trig=%b busy=%b expected 00 0 0", g16, trig16, busy16);
    end
    rst = 1'b0;
    step();
    tests++;
    if (busy16 !== 1'b1 || g16 !== 2'b00) begin failed++; $display("FAIL rmid_wait: busy=%b grant=%b expected 1 00", busy16, g16); end
    step();
    tests++;
    if (g16 !== 2'b01) begin failed++; $display("FAIL rmid_regrant: grant=%b expected 01", g16); end
    for (int k = 0; k < 16; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(8'h20 + k)};
      step();
      tests++;
      if (trig16 !== 1'b1 || data16 !== 8'(8'h20 + k) || cd16 !== 1'b0) begin
        failed++; $display("FAIL rmid_word%0d: trig=%b data=%h done=%b expected 1 %h 0", k, trig16, data16, cd16, 8'(8'h20 + k));
      end
    end
    in_valid = '0;
    step();
    tests++;
    if (cd16 !== 1'b1) begin failed++; $display("FAIL rmid_done: done=%b expected 1", cd16); end
    $display("[TB] reset mid-chunk checked");
  endtask

  task automatic test_padding();
    pulse_reset();
    req = 2'b01; prop = 1'b1;
    step(); step();
    for (int k = 0; k < 10; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(k)};
      step();
    end
    req = '0; in_valid = '0;
`ifdef AFIFO_WRITE_ARB_PAD_EN
    step();
    tests++;
    if (g16 !== 2'b00 || trig16 !== 1'b0) begin failed++; $display("FAIL pad_drop: grant=%b trig=%b expected 00 0", g16, trig16); end
    for (int k = 0; k < 6; k++) begin
      step();
      tests++;
      if (trig16 !== 1'b1 || data16 !== PAD) begin failed++; $display("FAIL pad_word%0d: trig=%b data=%h expected 1 %h", k, trig16, data16, PAD); end
    end
    step();
    tests++;
    if (cd16 !== 1'b1 || trig16 !== 1'b0) begin failed++; $display("FAIL pad_done: done=%b trig=%b expected 1 0", cd16, trig16); end
`else
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (g16 !== 2'b01 || trig16 !== 1'b0) begin failed++; $display("FAIL nopad_hold%0d: grant=%b trig=%b expected 01 0", k, g16, trig16); end
    end
    for (int k = 0; k < 6; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(8'h60 + k)};
      step();
      tests++;
      if (trig16 !== 1'b1 || data16 !== 8'(8'h60 + k)) begin
        failed++; $display("FAIL nopad_word%0d: trig=%b data=%h expected 1 %h", k, trig16, data16, 8'(8'h60 + k));
      end
    end
    in_valid = '0;
    step();
    tests++;
    if (cd16 !== 1'b1 || g16 !== 2'b00) begin failed++; $display("FAIL nopad_done: done=%b grant=%b expected 1 00", cd16, g16); end
    step();
    tests++;
    if (busy16 !== 1'b0) begin failed++; $display("FAIL nopad_idle: busy=%b expected 0", busy16); end
`endif
    $display("[TB] req drop mid-chunk checked");
  endtask

  task automatic test_random();
    logic [N-1:0] r, v;
    logic [W-1:0] lanes [N];
    int owner, wcnt, chunks, cyc;
    logic exp_done;
    for (int run = 0; run < 3; run++) begin
      pulse_reset();
      r = N'($urandom_range(1, 3));
      req = r;
      owner = next_owner(0, r);
      wcnt = 0; chunks = 0; cyc = 0; exp_done = 1'b0;
      while (chunks < 3 && cyc < 400) begin
        v = N'($urandom);
        for (int i = 0; i < N; i++) lanes[i] = W'($urandom);
        in_valid = v; in_data = {lanes[1], lanes[0]};
        prop = ($urandom_range(0, 9) < 7);
        step();
        tests++;
        if (cd4 !== exp_done) begin failed++; $display("FAIL rnd_done run%0d cyc%0d: done=%b expected %b", run, cyc, cd4, exp_done); end
        exp_done = 1'b0;
        if (g4 !== 2'b00) begin
          tests++;
          if (g4 !== onehot(owner)) begin failed++; $display("FAIL rnd_grant run%0d cyc%0d: grant=%b expected %b", run, cyc, g4, onehot(owner)); end
        end
        if (wcnt > 0) begin
          tests++;
          if (trig4 !== v[owner]) begin failed++; $display("FAIL rnd_trig run%0d cyc%0d: trig=%b expected %b", run, cyc, trig4, v[owner]); end
        end
        if (trig4 === 1'b1) begin
          tests++;
          if (v[owner] !== 1'b1 || data4 !== lanes[owner]) begin
            failed++; $display("FAIL rnd_data run%0d cyc%0d: data=%h valid=%b expected %h 1", run, cyc, data4, v[owner], lanes[owner]);
          end
          wcnt++;
          if (wcnt == 4) begin
            wcnt = 0; chunks++; exp_done = 1'b1; owner = next_owner(owner, r);
          end
        end
        cyc++;
      end
      tests++;
      if (chunks != 3) begin failed++; $display("FAIL rnd_timeout run%0d: chunks=%0d expected 3", run, chunks); end
      tests++;
      if (ovf4 !== 1'b0) begin failed++; $display("FAIL rnd_ovf run%0d: overflow=%b expected 0", run, ovf4); end
      $display("[TB] random run %0d req=%b: %0d chunks in %0d cycles", run, r, chunks, cyc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_bubbles_overflow();
    test_reset_mid();
    test_padding();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/afifo_write_arbiter.md
Name: afifo_write_arbiter

Overview:
- Producer-side scheduler for the AFIFOChain write port, in the prod_clk domain.
- Shares the single FIFO write port between N requesters (e.g. image readout and SD readout) in fixed-size chunks.
- Gates each chunk on prop_w_ready, so a reader on the far side only ever sees whole chunks.
- Replaces the hard-coded producer sequencing with a reusable grant/count/release controller.

Parameters:
- W, 8: FIFO word width in bits.
- N, 2: number of requesters (at least 2).
- CHUNK_LEN, 2048: words per granted chunk; equals half the chain capacity.
- PAD_WORD, 0: fill value used by the optional padding feature.

Ports:
- clk  in  1  producer clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-requester chunk request, level-sensitive.
- in_valid  in  N  per-requester word-valid; honoured only for the granted index.
- in_data  in  N*W  requester i data occupies bits [i*W +: W].
- grant  out  N  one-hot (or zero) current owner.
- chunk_done  out  1  one-cycle pulse after the last word of a chunk is issued.
- fifo_prop_w_ready  in  1  AFIFOChain: a full chunk of space is available.
- fifo_w_trigger  out  1  AFIFOChain write strobe.
- fifo_w_data  out  W  AFIFOChain write data.
- fifo_w_ready  in  1  AFIFOChain per-word ready.
- overflow  out  1  sticky error flag.
- busy  out  1  high in every state except Idle.

Behaviour:
- Reset: all outputs 0; state Idle; round-robin pointer 0; word counter 0.
- State Idle:
  - If any req is high, go to WaitReady.
- State WaitReady:
  - When fifo_prop_w_ready=1, pick the winner and go to Xfer.
  - Default arbitration is round-robin: start searching at pointer+1 mod N.
  - Assert the winner's grant bit on the next cycle and load counter=CHUNK_LEN.
  - If req drops to all-zero while waiting, return to Idle with no grant.
- State Xfer:
  - Each cycle with in_valid[g]=1: register fifo_w_trigger=1, fifo_w_data=in_data[g], and decrement the counter.
  - Latency from in_valid to fifo_w_trigger is exactly 1 cycle.
  - in_valid low inserts a bubble, with fifo_w_trigger=0 that cycle.
  - When the counter decrements to 0: clear grant on the following edge, pulse chunk_done, set pointer=g, go to Release.
  - req is ignored during Xfer unless the optional feature is compiled in.
- State Release:
  - One dead cycle that lets prop_w_ready fall.
  - Then go to WaitReady if any req is high, else Idle.
- Overflow:
  - Set when fifo_w_trigger=1 and fifo_w_ready=0 in the same cycle.
  - Sticky until rst; the word is still counted.
- Simultaneous requests: round-robin guarantees each active requester a grant within N chunks.
- Counter width is $clog2(CHUNK_LEN+1); CHUNK_LEN=1 is legal and produces a single-word chunk.
- Reset mid-chunk: grant drops immediately, because reset is asynchronous. The partial chunk stays in the FIFO; discarding it is the system's responsibility.
- prop_w_ready is sampled only in WaitReady; changes during Xfer are ignored.

Optional Feature:
- Macro: AFIFO_WRITE_ARB_PAD_EN.
- Defined:
  - If req[g] falls during Xfer, the arbiter drops grant the next cycle.
  - It then writes PAD_WORD once per cycle (subject to the same overflow check) until the counter reaches 0.
  - chunk_done then pulses as usual, so chunk boundaries are preserved.
- Undefined: req is ignored in Xfer, and the grant holds until CHUNK_LEN valid words have been received.

Decomposition:
- Shared package: state encoding (Idle, WaitReady, Xfer, Release) and the default CHUNK_LEN derived from AFIFOChain count (N_fifo/2 × 4096 / W).
- Sub-module rr_pick: combinational round-robin one-hot selector taking req and pointer. It is the natural split and is reusable by other arbiters.

Test Plan:
- Single requester: req[0]=1, prop_w_ready=1, valid every cycle, CHUNK_LEN=16, data 0..15.
  - Expect 16 fifo_w_trigger pulses, data 0..15, each 1 cycle after in_valid.
  - Then chunk_done one cycle after the last word, grant 0, and busy low once req drops.
- Contention: req=2'b11 continuously, CHUNK_LEN=4.
  - Expect grants in the order 1,0,1,0 (pointer starts at 0), with exactly 4 writes per grant and a 1-cycle Release gap between them.
- Backpressure: hold prop_w_ready=0 for 50 cycles with req[0]=1.
  - Expect no grant and no trigger; grant asserts the cycle after prop_w_ready rises.
- Bubbles and overflow: toggle in_valid 1,0,1,… and force fifo_w_ready=0 on the 3rd write.
  - Expect 4 writes spread across 8 cycles and overflow=1 from that cycle until rst.
- Reset mid-Xfer: assert rst after 5 of 16 words.
  - Expect grant, trigger, busy and counter at 0 immediately; after release, a fresh chunk starts from WaitReady.
- Padding (AFIFO_WRITE_ARB_PAD_EN defined): drop req[0] after 10 of 16 words.
  - Expect 6 writes of PAD_WORD on consecutive cycles and then chunk_done.
  - With the macro undefined, the same stimulus keeps grant high until 6 more valid words arrive.
